router_out_reader: RTL and testbench

- Read-side controller for one output port of the 1x3 router.
- Drains packets from a 16-deep FIFO over that FIFO's read_en/empty/data_out interface and presents them to the external receiver on a valid/ready byte stream.
- Marks packet boundaries, checks packet parity, and flushes a stalled packet after a timeout.
- One instance sits after each of the three FIFOs.

---
 rtl/router_out_reader.sv | 149 ++++++++++++++
 tb/tb_router_out_reader.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_out_reader.sv
// router_out_reader: read side of one router output port. Pulls bytes from the
// port FIFO, frames them into header/payload/parity, buffers them in a 2-entry
// skid buffer for a valid/ready receiver, flags parity errors and flushes a
// packet that has been stalled for TIMEOUT cycles.
module router_out_reader #(
  parameter int TIMEOUT = 30,
  parameter int TO_W    = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic       parity_err,
  output logic       soft_reset,
  output logic       busy
);

  typedef enum logic [1:0] {HDR, PAY, PAR} frame_e;
  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } ent_t;

  frame_e          frame_q, frame_d;
  logic            drop_q, drop_d;
  logic [7:0]      acc_q, acc_d;
  logic [5:0]      cnt_q, cnt_d;
  ent_t [1:0]      ent_q, ent_d;
  logic [1:0]      occ_q, occ_d;
  logic            pend_q;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            perr_q, perr_d;
  logic            srst_q;

  logic       drain, stall, flush, eop_in_buf, enter_drop, drop_now, keep;
  logic       sop_in, eop_in;
  logic [2:0] level;
  logic [1:0] occ_b;

  assign out_valid  = (occ_q != 2'd0);
  assign out_data   = ent_q[0].data;
  assign out_sop    = ent_q[0].sop;
  assign out_eop    = ent_q[0].eop;
  assign parity_err = perr_q;
  assign soft_reset = srst_q;
  assign busy       = (frame_q != HDR) || (occ_q != 2'd0);

  assign drain = out_valid && out_ready;
  assign stall = out_valid && !out_ready;
  // Flush on the TIMEOUT-th consecutive stalled cycle.
  assign flush = stall && (tcnt_q == TO_W'(TIMEOUT - 1));

  assign eop_in_buf = ((occ_q != 2'd0) && ent_q[0].eop) || ((occ_q == 2'd2) && ent_q[1].eop);
  // A flush that cuts a packet leaves its tail in the FIFO; that tail must be eaten.
  assign enter_drop = flush && ((frame_q != HDR) || !eop_in_buf);
  assign drop_now   = drop_q || enter_drop;
  assign keep       = pend_q && !drop_now;

  // Bytes already committed (buffered + in flight) minus the one leaving now.
  assign level      = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, drain};
  // Reads are held off during reset so no byte can return into a cleared pipeline.
  assign fifo_rd_en = resetn && !fifo_empty && (drop_q || (level < 3'd2));

  // Framing: track header/payload/parity and the running XOR of each arriving byte.
  always_comb begin
    frame_d = frame_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    drop_d  = drop_now;
    perr_d  = 1'b0;
    sop_in  = 1'b0;
    eop_in  = 1'b0;
    if (pend_q) begin
      case (frame_q)
        HDR: begin
          sop_in  = 1'b1;
          acc_d   = fifo_data;
          cnt_d   = fifo_data[7:2];
          frame_d = (fifo_data[7:2] != 6'd0) ? PAY : PAR;
        end
        PAY: begin
          acc_d = acc_q ^ fifo_data;
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) frame_d = PAR;
        end
        PAR: begin
          eop_in  = 1'b1;
          perr_d  = !drop_now && (fifo_data != acc_q);
          frame_d = HDR;
          drop_d  = 1'b0;
        end
        default: frame_d = HDR;
      endcase
    end
  end

  // Skid buffer: flush beats drain, then an arriving byte lands behind what remains.
  always_comb begin
    ent_d = ent_q;
    occ_b = flush ? 2'd0 : (occ_q - {1'b0, drain});
    if (!flush && drain) ent_d[0] = ent_q[1];
    occ_d = occ_b;
    if (keep) begin
      ent_d[occ_b[0]] = '{data: fifo_data, sop: sop_in, eop: eop_in};
      occ_d           = occ_b + 2'd1;
    end
  end

  // Stall timer: counts consecutive stalled cycles, restarts on anything else.
  always_comb begin
    tcnt_d = '0;
    if (stall && !flush) tcnt_d = tcnt_q + 1'b1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      frame_q <= HDR;
      drop_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ent_q   <= '0;
      occ_q   <= '0;
      pend_q  <= 1'b0;
      tcnt_q  <= '0;
      perr_q  <= 1'b0;
      srst_q  <= 1'b0;
    end else begin
      frame_q <= frame_d;
      drop_q  <= drop_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ent_q   <= ent_d;
      occ_q   <= occ_d;
      pend_q  <= fifo_rd_en;
      tcnt_q  <= tcnt_d;
      perr_q  <= perr_d;
      srst_q  <= flush;
    end
  end

endmodule

// File: tb/tb_router_out_reader.sv
// tb_router_out_reader: packet table, hand-written corner sequences and a
// randomized stream checked against a packet-level expectation queue.
module tb_router_out_reader;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty, fifo_rd_en, out_valid, out_sop, out_eop;
  logic       parity_err, soft_reset, busy;
  logic [7:0] out_data;

  int vec = 0;
  int miss = 0;

  router_out_reader #(.TIMEOUT(30), .TO_W(5)) dut (
    .clock(clock), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .parity_err(parity_err), .soft_reset(soft_reset), .busy(busy)
  );

  always #5 clock = ~clock;

  // FIFO model: data appears on fifo_data the cycle after a read.
  logic [7:0] fmem [0:8191];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clock) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fmem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor: collects accepted bytes and pulse counts, watches protocol rules.
  typedef struct packed {logic [7:0] d; logic s; logic e;} obs_t;
  obs_t got[$];
  int   perr_cnt = 0, srst_cnt = 0;
  int   viol_rd_empty = 0, viol_stab = 0, viol_cap = 0;
  int   inflight = 0;
  bit   chk_cap = 0;
  logic prev_stall = 1'b0;
  obs_t prev_head = '0;
  always @(negedge clock) begin
    if (fifo_rd_en && fifo_empty) viol_rd_empty++;
    if (prev_stall && !soft_reset && !(out_valid && {out_data, out_sop, out_eop} == prev_head))
      viol_stab++;
    if (resetn) begin
      if (out_valid && out_ready) got.push_back({out_data, out_sop, out_eop});
      if (parity_err) perr_cnt++;
      if (soft_reset) srst_cnt++;
      if (chk_cap && (fifo_rd_en != (!fifo_empty && (inflight - int'(out_valid && out_ready)) < 2)))
        viol_cap++;
    end
    if (!chk_cap || !resetn) inflight = 0;
    else inflight = inflight + int'(fifo_rd_en && !fifo_empty) - int'(out_valid && out_ready);
    prev_stall = resetn && out_valid && !out_ready;
    prev_head  = {out_data, out_sop, out_eop};
  end

  task automatic check(input string nm, input int act, input int exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic push_n(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) push(bytes[8*i +: 8]);
  endtask

  // Wait (bounded) until target bytes have been accepted and the block is idle.
  task automatic drain_until(input string nm, input int target);
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (got.size() >= target && !busy) begin ok = 1; break; end
    end
    repeat (2) @(negedge clock);
    check({nm, "_done"}, int'(ok), 1);
  endtask

  // Compare accepted bytes against one packet: sop on first, eop on last.
  task automatic cmp_pkt(input string nm, input int base, input logic [63:0] bytes, input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = {bytes[8*i +: 8], i == 0, i == n - 1};
      if (base + i < got.size()) check({nm, "_byte"}, int'(got[base + i]), int'(e));
      else check({nm, "_missing"}, base + i, -1);
    end
  endtask

  typedef struct {
    logic [63:0] bytes;  // byte 0 in the low bits
    int          n;
    int          exp_err;
  } tvec_t;

  initial begin
    tvec_t tbl [8];
    int g0, p0, s0, r, r1, f, run, thr, gaps, pcnt, pidx, stalls, vbad, zrun, bad, k0;
    bit seen;
    logic rd_h [32];
    logic vld_h [32];
    logic pe_h [32];
    logic [7:0] bq[$];
    obs_t rexp[$];

    // 0x0D^0x11^0x22^0x33 works out to 0x0D; 0x1F is kept as a bad-parity case.
    tbl[0] = '{64'h0D_33_22_11_0D, 5, 0};
    tbl[1] = '{64'h03_02, 2, 1};
    tbl[2] = '{64'h02_02, 2, 0};
    tbl[3] = '{64'hAF_AA_05, 3, 0};
    tbl[4] = '{64'h8A_01_80_0B, 4, 0};
    tbl[5] = '{64'h8B_01_80_0B, 4, 1};
    tbl[6] = '{64'h00_00, 2, 0};
    tbl[7] = '{64'h1F_33_22_11_0D, 5, 1};

    // Reset state
    repeat (2) cyc();
    @(negedge clock);
    check("reset_outputs", int'({fifo_rd_en, out_valid, out_sop, out_eop, parity_err,
                                 soft_reset, busy, out_data}), 0);
    cyc();
    resetn  = 1'b1;
    chk_cap = 1;
    out_ready = 1'b1;

    // Table of packets, receiver always ready
    for (int v = 0; v < 8; v++) begin
      cyc();
      g0 = got.size(); p0 = perr_cnt;
      push_n(tbl[v].bytes, tbl[v].n);
      drain_until($sformatf("tbl%0d", v), g0 + tbl[v].n);
      check($sformatf("tbl%0d_len", v), got.size() - g0, tbl[v].n);
      cmp_pkt($sformatf("tbl%0d", v), g0, tbl[v].bytes, tbl[v].n);
      check($sformatf("tbl%0d_perr", v), perr_cnt - p0, tbl[v].exp_err);
      check($sformatf("tbl%0d_busy", v), int'(busy), 0);
    end

    // Latency and streaming: byte reaches fifo_data one cycle after the read,
    // and out_valid one cycle after that; then 5 back-to-back valid cycles.
    cyc();
    g0 = got.size();
    push_n(tbl[0].bytes, 5);
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      rd_h[k] = fifo_rd_en; vld_h[k] = out_valid;
    end
    r = -1; f = -1; run = 0;
    for (int k = 15; k >= 0; k--) begin
      if (rd_h[k]) r = k;
      if (vld_h[k]) f = k;
    end
    for (int k = f; k >= 0 && k < 16 && vld_h[k]; k++) run++;
    check("lat_rd_to_valid", f - r, 2);
    check("lat_valid_run", run, 5);
    drain_until("lat", g0 + 5);
    cmp_pkt("lat", g0, tbl[0].bytes, 5);

    // Backpressure: ready pattern 1,0,0 repeating
    cyc();
    g0 = got.size(); thr = 0;
    push_n(tbl[0].bytes, 5);
    for (int k = 0; k < 30; k++) begin
      out_ready = (k % 3 == 0);
      @(negedge clock);
      if (!fifo_rd_en && !fifo_empty) thr++;
      cyc();
    end
    out_ready = 1'b1;
    drain_until("bp", g0 + 5);
    check("bp_len", got.size() - g0, 5);
    cmp_pkt("bp", g0, tbl[0].bytes, 5);
    check("bp_throttled", int'(thr > 0), 1);

    // Parity error on an L=0 packet: pulse once, 1 cycle after the parity byte lands
    cyc();
    g0 = got.size();
    push(8'h02); push(8'h03);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      rd_h[k] = fifo_rd_en; pe_h[k] = parity_err;
    end
    r = 0; r1 = -1; pcnt = 0; pidx = -1;
    for (int k = 0; k < 12; k++) begin
      if (rd_h[k]) begin r++; if (r == 2) r1 = k; end
      if (pe_h[k]) begin pcnt++; pidx = k; end
    end
    check("perr_count", pcnt, 1);
    check("perr_timing", pidx - r1, 2);
    drain_until("perr", g0 + 2);
    cmp_pkt("perr", g0, 64'h03_02, 2);

    // Back-to-back packets: reads every cycle, no gap between eop and sop
    cyc();
    g0 = got.size(); gaps = 0;
    push_n(64'h0A_02_01_09_51_55_04, 7);
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      if (!fifo_empty && !fifo_rd_en) gaps++;
      vld_h[k] = out_valid;
    end
    f = -1; run = 0;
    for (int k = 15; k >= 0; k--) if (vld_h[k]) f = k;
    for (int k = f; k >= 0 && k < 16 && vld_h[k]; k++) run++;
    check("b2b_rd_gaps", gaps, 0);
    check("b2b_valid_run", run, 7);
    drain_until("b2b", g0 + 7);
    cmp_pkt("b2b_a", g0, 64'h51_55_04, 3);
    cmp_pkt("b2b_b", g0 + 3, 64'h0A_02_01_09, 4);

    // Timeout flush mid-packet, then the next packet must come through intact
    cyc();
    chk_cap = 0;
    out_ready = 1'b0;
    s0 = srst_cnt; p0 = perr_cnt; g0 = got.size();
    stalls = 0; seen = 0;
    push_n(64'h14_04_03_02_01_10, 6);
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (soft_reset) begin seen = 1; break; end
      if (out_valid && !out_ready) stalls++;
    end
    check("to_seen", int'(seen), 1);
    check("to_stall_cycles", stalls, 30);
    check("to_valid_after", int'(out_valid), 0);
    vbad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (out_valid) vbad++;
    end
    check("to_no_output", vbad, 0);
    check("to_fifo_drained", int'(fifo_empty), 1);
    check("to_busy", int'(busy), 0);
    check("to_pulse_once", srst_cnt - s0, 1);
    cyc();
    out_ready = 1'b1;
    push_n(64'hAF_AA_05, 3);
    drain_until("to_next", g0 + 3);
    check("to_next_len", got.size() - g0, 3);
    cmp_pkt("to_next", g0, 64'hAF_AA_05, 3);
    check("to_perr", perr_cnt - p0, 0);

    // Reset with a read pending mid-packet
    cyc();
    push(8'h0D); push(8'h11);
    r = 0;
    for (int k = 0; k < 10 && r < 2; k++) begin
      @(negedge clock);
      if (fifo_rd_en) r++;
    end
    check("rst_reads", r, 2);
    cyc();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    @(negedge clock);
    check("rst_outputs", int'({out_valid, out_sop, out_eop, parity_err, soft_reset, busy, out_data}), 0);
    cyc();
    g0 = got.size(); p0 = perr_cnt;
    push_n(64'h51_55_04, 3);
    drain_until("rst_next", g0 + 3);
    check("rst_next_len", got.size() - g0, 3);
    cmp_pkt("rst_next", g0, 64'h51_55_04, 3);
    check("rst_perr", perr_cnt - p0, 0);

    // Random packets, random arrival and random (bounded) backpressure
    cyc();
    chk_cap = 1;
    g0 = got.size(); p0 = perr_cnt; s0 = srst_cnt; bad = 0;
    for (int p = 0; p < 40; p++) begin
      logic [7:0] h, b, par;
      int len;
      len = $urandom_range(0, 6);
      h   = {6'(len), 2'($urandom_range(0, 3))};
      par = h;
      bq.push_back(h);
      rexp.push_back({h, 1'b1, 1'b0});
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(0, 255));
        par = par ^ b;
        bq.push_back(b);
        rexp.push_back({b, 1'b0, 1'b0});
      end
      if ($urandom_range(0, 3) == 0) begin
        par = par ^ (8'h01 << $urandom_range(0, 7));
        bad++;
      end
      bq.push_back(par);
      rexp.push_back({par, 1'b0, 1'b1});
    end
    zrun = 0; k0 = 0;
    for (int c = 0; c < 6000; c++) begin
      cyc();
      if (bq.size() != 0 && $urandom_range(0, 3) != 0) push(bq.pop_front());
      if (zrun >= 8) out_ready = 1'b1;
      else out_ready = ($urandom_range(0, 3) != 0);
      zrun = out_ready ? 0 : zrun + 1;
      k0 = c;
      if (bq.size() == 0 && got.size() >= g0 + rexp.size() && !busy) break;
    end
    out_ready = 1'b1;
    repeat (4) @(negedge clock);
    check("rnd_finished", int'(k0 < 5999), 1);
    check("rnd_len", got.size() - g0, rexp.size());
    for (int i = 0; i < rexp.size(); i++) begin
      if (g0 + i < got.size()) check($sformatf("rnd_byte%0d", i), int'(got[g0 + i]), int'(rexp[i]));
    end
    check("rnd_perr", perr_cnt - p0, bad);
    check("rnd_no_flush", srst_cnt - s0, 0);

    // Protocol rules watched over the whole run
    check("rd_while_empty", viol_rd_empty, 0);
    check("stall_stability", viol_stab, 0);
    check("read_issue_rule", viol_cap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, %0d vectors applied", vec);
    $fatal(1);
  end

endmodule
